rom_load_arb: RTL and testbench
===============================

ROM_LOAD_ARB -- requirements
Module: rom_load_arb

Interface
REQ-001 Parameter REGION_W, default 13, log2 of bytes per region (BIOS region and cart region, 8 KiB each).
REQ-002 clk_sys  in  1  system clock; every flop is clocked on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 ioctl_download  in  1  HPS download in progress.
REQ-005 ioctl_index  in  8  download target: 0 selects BIOS, 1 selects cart, any other value is ignored.
REQ-006 ioctl_wr  in  1  one-clock strobe marking a valid download word.
REQ-007 ioctl_addr  in  25  byte address of the word (even).
REQ-008 ioctl_dout  in  16  download word; [7:0] goes to addr, [15:8] to addr+1.
REQ-009 ioctl_wait  out  1  download stall request back to HPS.
REQ-010 bios_addr  in  REGION_W  CPU BIOS read address.
REQ-011 bios_do  out  8  registered BIOS read data.
REQ-012 cart_addr  in  REGION_W  CPU cart read address.
REQ-013 cart_do  out  8  registered cart read data.
REQ-014 mem_addr  out  REGION_W+1  shared single-port RAM address; MSB 0 = BIOS, 1 = cart.
REQ-015 mem_din  out  8  RAM write data.
REQ-016 mem_we  out  1  RAM write enable.
REQ-017 mem_q  in  8  RAM read data, valid one clock after mem_addr.
REQ-018 cart_size  out  REGION_W+1  number of cart bytes loaded.
REQ-019 load_done  out  1  one-clock pulse at the end of a download.
REQ-020 overrun  out  1  sticky flag: an ioctl_wr arrived while the block was busy.

Function
REQ-021 The FSM SHALL have four states: IDLE, WR_LO, WR_HI, RUN. It leaves reset in IDLE.
REQ-022 IDLE:
- ioctl_download=1 goes to RUN only after that signal falls; otherwise IDLE goes to RUN directly.
- ioctl_download=1 with index 0 or 1 is the load sub-mode.
- In RUN, a rising edge of ioctl_download returns the FSM to IDLE.
REQ-023 Load, ioctl_wr=1 with a valid index and ioctl_addr < 2^REGION_W:
- latch addr and word;
- set ioctl_wait=1 on the next clock;
- go to WR_LO.
REQ-024 Load, ioctl_wr=1 with an invalid index or an out-of-range address: drop the word, produce no mem_we, and leave ioctl_wait at 0.
REQ-025 WR_LO:
- drive mem_we=1, mem_addr={region, addr}, mem_din=word[7:0];
- go to WR_HI.
REQ-026 WR_HI:
- drive mem_we=1, mem_addr={region, addr+1}, mem_din=word[15:8];
- deassert ioctl_wait;
- return to IDLE.
- ioctl_wait is therefore high for exactly 2 clocks per accepted word.
REQ-027 A WR_LO/WR_HI pair already started SHALL complete even if ioctl_download falls mid-pair.
REQ-028 ioctl_wr=1 in WR_LO or WR_HI SHALL be dropped and SHALL set overrun; overrun clears only on reset.
REQ-029 cart_size:
- clears to 0 on the rising edge of ioctl_download when ioctl_index=1;
- after each accepted cart word, becomes max(cart_size, addr+2).
REQ-030 load_done SHALL pulse for 1 clock on the falling edge of ioctl_download, after any pending write pair completes.
REQ-031 RUN time-slots the RAM with a 1-bit slot toggle every clock:
- slot 0 drives {0, bios_addr};
- slot 1 drives {1, mapped cart address}.
REQ-032 Returned data routing:
- mem_q from a slot-0 address is registered into bios_do on the following clock;
- mem_q from a slot-1 address is registered into cart_do on the following clock;
- worst-case address-to-data latency is 3 clocks.
REQ-033 Cart mapping (mirroring):
- cart_size ≤ 2048: cart_addr[10:0];
- cart_size ≤ 4096: cart_addr[11:0];
- otherwise: cart_addr unmodified.
REQ-034 If cart_size=0, or the mapped cart address ≥ cart_size, cart_do SHALL be 0xFF instead of mem_q.
REQ-035 mem_we SHALL be 0 in every state except WR_LO and WR_HI; bios_do and cart_do hold their values outside RUN.

Reset
REQ-036 While reset_n=0:
- state=IDLE, slot=0;
- ioctl_wait=0, mem_we=0, mem_addr=0, mem_din=0;
- bios_do=0xFF, cart_do=0xFF;
- cart_size=0, load_done=0, overrun=0.
REQ-037 Reset asserted mid write-pair SHALL abort the pair with no further mem_we.

Structure
REQ-038 A shared package SHALL hold the state enum, the constants IDX_BIOS=0, IDX_CART=1, MIRROR_2K=2048, MIRROR_4K=4096, and the open-bus value 0xFF.
REQ-039 One sub-module, rom_cart_mirror, SHALL be combinational: cart_addr + cart_size in, mapped address + out-of-range flag out.

Verification
REQ-040 BIOS load: index 0, word 0xA55A at addr 0x10 → mem_we at {0,0x10}=0x5A, then {0,0x11}=0xA5; ioctl_wait high exactly 2 clocks.
REQ-041 Cart 2 KiB load, then RUN with cart_addr=0x0805 → cart_do equals the byte at 0x005 within 3 clocks; cart_size=2048.
REQ-042 Cart of 3000 bytes, cart_addr=0x0BB8 → cart_do=0xFF; cart_addr=0x0BB7 → the loaded byte.
REQ-043 ioctl_wr repeated 1 clock after an accepted word → second word dropped, overrun=1, exactly 2 mem_we pulses.
REQ-044 ioctl_index=2 word → no mem_we, ioctl_wait stays 0; ioctl_download falls during WR_LO → WR_HI still written, then load_done pulses once.
REQ-045 reset_n low during WR_LO → no WR_HI write; all outputs at reset values the same clock.

Source files
------------

// File: rtl/rom_load_arb_pkg.sv
// rtl/rom_load_arb_pkg.sv - shared state type and constants for the ROM download arbiter
package rom_load_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_LO,
    ST_WR_HI,
    ST_RUN
  } state_t;

  localparam logic [7:0]  IDX_BIOS  = 8'd0;
  localparam logic [7:0]  IDX_CART  = 8'd1;
  localparam logic [31:0] MIRROR_2K = 32'd2048;
  localparam logic [31:0] MIRROR_4K = 32'd4096;
  localparam logic [7:0]  OPEN_BUS  = 8'hFF;

endpackage

// File: rtl/rom_cart_mirror.sv
// rtl/rom_cart_mirror.sv - combinational cart address mirroring and bounds flag
module rom_cart_mirror
  import rom_load_arb_pkg::*;
#(
  parameter int REGION_W = 13
) (
  input  logic [REGION_W-1:0] i_cart_addr,
  input  logic [REGION_W:0]   i_cart_size,
  output logic [REGION_W-1:0] o_mapped_addr,
  output logic                o_out_of_range
);

  logic [31:0]         w_size32;
  logic [REGION_W-1:0] w_mask;

  // Small carts repeat across the window so images built for 2K/4K decode correctly
  always_comb begin
    w_size32 = 32'(i_cart_size);
    if (w_size32 <= MIRROR_2K) begin
      w_mask = (REGION_W)'(MIRROR_2K - 32'd1);
    end else if (w_size32 <= MIRROR_4K) begin
      w_mask = (REGION_W)'(MIRROR_4K - 32'd1);
    end else begin
      w_mask = '1;
    end
    o_mapped_addr  = i_cart_addr & w_mask;
    o_out_of_range = (i_cart_size == '0) || ({1'b0, o_mapped_addr} >= i_cart_size);
  end

endmodule

// File: rtl/rom_load_arb.sv
// rtl/rom_load_arb.sv - arbitrates a single-port ROM RAM between HPS download and CPU BIOS/cart reads
module rom_load_arb
  import rom_load_arb_pkg::*;
#(
  parameter int REGION_W = 13
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ioctl_download,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [15:0]         ioctl_dout,
  output logic                ioctl_wait,
  input  logic [REGION_W-1:0] bios_addr,
  output logic [7:0]          bios_do,
  input  logic [REGION_W-1:0] cart_addr,
  output logic [7:0]          cart_do,
  output logic [REGION_W:0]   mem_addr,
  output logic [7:0]          mem_din,
  output logic                mem_we,
  input  logic [7:0]          mem_q,
  output logic [REGION_W:0]   cart_size,
  output logic                load_done,
  output logic                overrun
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_slot;
  logic                r_dl_prev;
  logic                r_region;
  logic [REGION_W-1:0] r_addr;
  logic [15:0]         r_word;
  logic [REGION_W:0]   r_cart_size;
  logic [7:0]          r_bios_do;
  logic [7:0]          r_cart_do;
  logic                r_load_done;
  logic                r_done_pend;
  logic                r_overrun;
  logic                r_pend_valid;
  logic                r_pend_slot;
  logic                r_pend_oob;

  logic                w_dl_rise;
  logic                w_dl_fall;
  logic                w_idx_ok;
  logic                w_addr_ok;
  logic                w_accept;
  logic                w_busy;
  logic                w_done_now;
  logic [REGION_W-1:0] w_cart_map;
  logic                w_cart_oob;
  logic [REGION_W:0]   w_wr_end;
  logic [REGION_W:0]   w_size_base;
  logic [REGION_W:0]   w_size_nxt;

  rom_cart_mirror #(
    .REGION_W(REGION_W)
  ) u_mirror (
    .i_cart_addr   (cart_addr),
    .i_cart_size   (r_cart_size),
    .o_mapped_addr (w_cart_map),
    .o_out_of_range(w_cart_oob)
  );

  assign w_dl_rise  = ioctl_download & ~r_dl_prev;
  assign w_dl_fall  = ~ioctl_download & r_dl_prev;
  assign w_idx_ok   = (ioctl_index == IDX_BIOS) || (ioctl_index == IDX_CART);
  assign w_addr_ok  = (ioctl_addr >> REGION_W) == 25'd0;
  assign w_accept   = (r_state == ST_IDLE) && ioctl_download && ioctl_wr && w_idx_ok && w_addr_ok;
  assign w_busy     = (r_state == ST_WR_LO) || (r_state == ST_WR_HI);
  // The end-of-download pulse waits until an in-flight byte pair has landed
  assign w_done_now = (w_dl_fall | r_done_pend) & ~w_busy;
  assign w_wr_end   = {1'b0, ioctl_addr[REGION_W-1:0]} + (REGION_W+1)'(2);

  always_comb begin
    w_size_base = ((w_dl_rise == 1'b1) && (ioctl_index == IDX_CART)) ? '0 : r_cart_size;
    w_size_nxt  = w_size_base;
    if (w_accept && (ioctl_index == IDX_CART) && (w_wr_end > w_size_base)) begin
      w_size_nxt = w_wr_end;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_WR_LO;
        end else if (!ioctl_download) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_WR_LO: begin
        mem_we      = 1'b1;
        mem_addr    = {r_region, r_addr};
        mem_din     = r_word[7:0];
        w_state_nxt = ST_WR_HI;
      end
      ST_WR_HI: begin
        mem_we      = 1'b1;
        mem_addr    = {r_region, r_addr[REGION_W-1:1], 1'b1};
        mem_din     = r_word[15:8];
        w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        mem_addr = r_slot ? {1'b1, w_cart_map} : {1'b0, bios_addr};
        if (w_dl_rise) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_slot       <= 1'b0;
      r_dl_prev    <= 1'b0;
      r_region     <= 1'b0;
      r_addr       <= '0;
      r_word       <= '0;
      r_cart_size  <= '0;
      r_bios_do    <= OPEN_BUS;
      r_cart_do    <= OPEN_BUS;
      r_load_done  <= 1'b0;
      r_done_pend  <= 1'b0;
      r_overrun    <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_slot  <= 1'b0;
      r_pend_oob   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dl_prev   <= ioctl_download;
      r_slot      <= (r_state == ST_RUN) ? ~r_slot : 1'b0;
      r_cart_size <= w_size_nxt;
      r_load_done <= w_done_now;
      r_done_pend <= (w_dl_fall | r_done_pend) & ~w_done_now;
      if (w_accept) begin
        r_addr   <= ioctl_addr[REGION_W-1:0];
        r_word   <= ioctl_dout;
        r_region <= (ioctl_index == IDX_CART);
      end
      if (ioctl_wr && w_busy) begin
        r_overrun <= 1'b1;
      end
      // mem_q lags the address by one clock, so the slot and bounds flag ride along
      r_pend_valid <= (r_state == ST_RUN);
      r_pend_slot  <= r_slot;
      r_pend_oob   <= w_cart_oob;
      if (r_pend_valid) begin
        if (r_pend_slot) begin
          r_cart_do <= r_pend_oob ? OPEN_BUS : mem_q;
        end else begin
          r_bios_do <= mem_q;
        end
      end
    end
  end

  assign ioctl_wait = w_busy;
  assign bios_do    = r_bios_do;
  assign cart_do    = r_cart_do;
  assign cart_size  = r_cart_size;
  assign load_done  = r_load_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_rom_load_arb.sv
// tb/tb_rom_load_arb.sv - scoreboard bench for rom_load_arb with a behavioural single-port RAM
module tb_rom_load_arb;

  localparam int REGION_W = 13;

  logic                clk_sys = 1'b0;
  logic                reset_n;
  logic                ioctl_download;
  logic [7:0]          ioctl_index;
  logic                ioctl_wr;
  logic [24:0]         ioctl_addr;
  logic [15:0]         ioctl_dout;
  logic                ioctl_wait;
  logic [REGION_W-1:0] bios_addr;
  logic [7:0]          bios_do;
  logic [REGION_W-1:0] cart_addr;
  logic [7:0]          cart_do;
  logic [REGION_W:0]   mem_addr;
  logic [7:0]          mem_din;
  logic                mem_we;
  logic [7:0]          mem_q;
  logic [REGION_W:0]   cart_size;
  logic                load_done;
  logic                overrun;

  typedef struct packed {
    logic [REGION_W:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         checks   = 0;
  int         failures = 0;
  int         we_count = 0;
  logic [7:0] ram [0:(1<<(REGION_W+1))-1];

  always #5 clk_sys = ~clk_sys;

  rom_load_arb #(.REGION_W(REGION_W)) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .bios_addr     (bios_addr),
    .bios_do       (bios_do),
    .cart_addr     (cart_addr),
    .cart_do       (cart_do),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_we        (mem_we),
    .mem_q         (mem_q),
    .cart_size     (cart_size),
    .load_done     (load_done),
    .overrun       (overrun)
  );

  always @(posedge clk_sys) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_q <= ram[mem_addr];
  end

  always @(negedge clk_sys) begin
    if (mem_we === 1'b1) begin
      we_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%h data=%h expected none", mem_addr, mem_din);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_addr, mem_din} !== mon_e) begin
          failures++;
          $display("FAIL write_order got addr=%h data=%h expected addr=%h data=%h",
                   mem_addr, mem_din, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic drive_dl(input logic v, input logic [7:0] idx);
    @(posedge clk_sys); #1;
    ioctl_download = v;
    ioctl_index    = idx;
  endtask

  task automatic send_word(input logic [24:0] a, input logic [15:0] d, input logic ok,
                           output int wait_cnt);
    @(posedge clk_sys); #1;
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (ok) begin
      exp_q.push_back({(ioctl_index == 8'd1), a[REGION_W-1:0], d[7:0]});
      exp_q.push_back({(ioctl_index == 8'd1), a[REGION_W-1:1], 1'b1, d[15:8]});
    end
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    wait_cnt = 0;
    repeat (4) begin
      @(negedge clk_sys);
      if (ioctl_wait === 1'b1) wait_cnt++;
    end
  endtask

  task automatic set_read(input logic [REGION_W-1:0] b, input logic [REGION_W-1:0] c);
    @(posedge clk_sys); #1;
    bios_addr = b;
    cart_addr = c;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; bios_addr = '0; cart_addr = '0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({ioctl_wait, mem_we, load_done, overrun} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got wait/we/done/ovr=%b expected 0000",
               {ioctl_wait, mem_we, load_done, overrun});
    end
    checks++;
    if (mem_addr !== '0 || mem_din !== 8'h00) begin
      failures++;
      $display("FAIL reset_mem got addr=%h din=%h expected 0/00", mem_addr, mem_din);
    end
    checks++;
    if (bios_do !== 8'hFF || cart_do !== 8'hFF) begin
      failures++;
      $display("FAIL reset_data got bios=%h cart=%h expected FF/FF", bios_do, cart_do);
    end
    checks++;
    if (cart_size !== '0) begin
      failures++;
      $display("FAIL reset_cart_size got %0d expected 0", cart_size);
    end
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk_sys);
  endtask

  task automatic test_bios_load();
    int wc;
    int pulses;
    drive_dl(1'b1, 8'd0);
    send_word(25'h10, 16'hA55A, 1'b1, wc);
    checks++;
    if (wc != 2) begin
      failures++;
      $display("FAIL bios_wait_cycles got %0d expected 2", wc);
    end
    drive_dl(1'b0, 8'd0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk_sys);
      if (load_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL bios_load_done got %0d pulses expected 1", pulses);
    end
  endtask

  task automatic test_cart_2k();
    int wc;
    drive_dl(1'b1, 8'd1);
    send_word(25'h004, 16'h3C21, 1'b1, wc);
    send_word(25'h7FE, 16'h7788, 1'b1, wc);
    drive_dl(1'b0, 8'd1);
    repeat (4) @(posedge clk_sys);
    checks++;
    if (cart_size !== 14'd2048) begin
      failures++;
      $display("FAIL cart2k_size got %0d expected 2048", cart_size);
    end
    set_read(13'h010, 13'h0805);
    checks++;
    if (cart_do !== 8'h3C) begin
      failures++;
      $display("FAIL cart2k_mirror got %h expected 3C", cart_do);
    end
    checks++;
    if (bios_do !== 8'h5A) begin
      failures++;
      $display("FAIL bios_read_lo got %h expected 5A", bios_do);
    end
    set_read(13'h011, 13'h0004);
    checks++;
    if (bios_do !== 8'hA5 || cart_do !== 8'h21) begin
      failures++;
      $display("FAIL read_pair got bios=%h cart=%h expected A5/21", bios_do, cart_do);
    end
  endtask

  task automatic test_cart_3000();
    int wc;
    drive_dl(1'b1, 8'd1);
    @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if (cart_size !== '0) begin
      failures++;
      $display("FAIL cart_size_clear got %0d expected 0", cart_size);
    end
    send_word(25'hBB6, 16'hD00B, 1'b1, wc);
    drive_dl(1'b0, 8'd1);
    repeat (4) @(posedge clk_sys);
    checks++;
    if (cart_size !== 14'd3000) begin
      failures++;
      $display("FAIL cart3000_size got %0d expected 3000", cart_size);
    end
    set_read(13'h000, 13'h0BB8);
    checks++;
    if (cart_do !== 8'hFF) begin
      failures++;
      $display("FAIL cart_past_end got %h expected FF", cart_do);
    end
    set_read(13'h000, 13'h0BB7);
    checks++;
    if (cart_do !== 8'hD0) begin
      failures++;
      $display("FAIL cart_last_byte got %h expected D0", cart_do);
    end
    set_read(13'h000, 13'h1BB7);
    checks++;
    if (cart_do !== 8'hD0) begin
      failures++;
      $display("FAIL cart_mirror4k got %h expected D0", cart_do);
    end
  endtask

  task automatic test_overrun();
    int we0;
    drive_dl(1'b1, 8'd0);
    we0 = we_count;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b1; ioctl_addr = 25'h50; ioctl_dout = 16'h1357;
    exp_q.push_back({1'b0, 13'h050, 8'h57});
    exp_q.push_back({1'b0, 13'h051, 8'h13});
    @(posedge clk_sys); #1;
    ioctl_addr = 25'h52; ioctl_dout = 16'h9999;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    repeat (5) @(negedge clk_sys);
    checks++;
    if (we_count - we0 != 2) begin
      failures++;
      $display("FAIL overrun_we_count got %0d expected 2", we_count - we0);
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_flag got %b expected 1", overrun);
    end
    drive_dl(1'b0, 8'd0);
    repeat (4) @(posedge clk_sys);
  endtask

  task automatic test_invalid();
    int wc;
    int we0;
    we0 = we_count;
    drive_dl(1'b1, 8'd2);
    send_word(25'h30, 16'h1234, 1'b0, wc);
    checks++;
    if (wc != 0) begin
      failures++;
      $display("FAIL bad_index_wait got %0d expected 0", wc);
    end
    drive_dl(1'b1, 8'd0);
    send_word(25'h2000, 16'h4321, 1'b0, wc);
    checks++;
    if (wc != 0 || we_count != we0) begin
      failures++;
      $display("FAIL out_of_range got wait=%0d writes=%0d expected 0/0", wc, we_count - we0);
    end
    checks++;
    if (cart_size !== 14'd3000) begin
      failures++;
      $display("FAIL cart_size_kept got %0d expected 3000", cart_size);
    end
    drive_dl(1'b0, 8'd0);
    repeat (4) @(posedge clk_sys);
  endtask

  task automatic test_fall_mid_pair();
    int we0;
    int pulses;
    drive_dl(1'b1, 8'd0);
    we0 = we_count;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b1; ioctl_addr = 25'h40; ioctl_dout = 16'hBEEF;
    exp_q.push_back({1'b0, 13'h040, 8'hEF});
    exp_q.push_back({1'b0, 13'h041, 8'hBE});
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk_sys);
      if (load_done === 1'b1) pulses++;
    end
    checks++;
    if (we_count - we0 != 2) begin
      failures++;
      $display("FAIL fall_mid_pair_writes got %0d expected 2", we_count - we0);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL fall_mid_pair_done got %0d pulses expected 1", pulses);
    end
  endtask

  task automatic test_reset_mid_pair();
    int we0;
    drive_dl(1'b1, 8'd0);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b1; ioctl_addr = 25'h60; ioctl_dout = 16'h6666;
    @(posedge clk_sys); #1;
    reset_n = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    we0 = we_count;
    @(negedge clk_sys);
    checks++;
    if ({ioctl_wait, mem_we, overrun, load_done} !== 4'b0000 || mem_addr !== '0) begin
      failures++;
      $display("FAIL reset_mid_pair got wait/we/ovr/done=%b addr=%h expected 0000/0",
               {ioctl_wait, mem_we, overrun, load_done}, mem_addr);
    end
    checks++;
    if (cart_size !== '0 || bios_do !== 8'hFF || cart_do !== 8'hFF) begin
      failures++;
      $display("FAIL reset_mid_pair_data got size=%0d bios=%h cart=%h expected 0/FF/FF",
               cart_size, bios_do, cart_do);
    end
    repeat (2) @(negedge clk_sys);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    checks++;
    if (we_count != we0) begin
      failures++;
      $display("FAIL reset_mid_pair_no_hi got %0d writes expected 0", we_count - we0);
    end
  endtask

  task automatic test_drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << (REGION_W + 1)); i++) ram[i] = 8'h00;
    test_reset();
    test_bios_load();
    test_cart_2k();
    test_cart_3000();
    test_overrun();
    test_invalid();
    test_fall_mid_pair();
    test_reset_mid_pair();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
